tinytpu_seq_ctrl: RTL and testbench
===================================

TINYTPU_SEQ_CTRL -- requirements
Module: tinytpu_seq_ctrl

Interface
REQ-001 Parameter D_W, default 8: operand word width in bits.
REQ-002 Parameter N, default 2: systolic array dimension, giving N*N result words.
REQ-003 Parameter WORD, default 2: words per operand vector; total operand words per stream is N*WORD.
REQ-004 Parameter ACC_W, default 16: result word width in bits.
REQ-005 Port clk, input, 1: single clock; all logic SHALL be rising-edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port data_in_x, input, 1: serial X operand bit, LSB first.
REQ-008 Port data_in_y, input, 1: serial Y operand bit, LSB first.
REQ-009 Port load_en, input, 1: qualifies data_in_x and data_in_y bits.
REQ-010 Port init, input, 1: clear/abort request.
REQ-011 Port x_word, output, D_W: deserialized X word to the array.
REQ-012 Port y_word, output, D_W: deserialized Y word to the array.
REQ-013 Port word_valid, output, 1: one-cycle strobe; x_word and y_word are valid.
REQ-014 Port array_clear, output, 1: one-cycle accumulator clear to the array.
REQ-015 Port array_step, output, 1: array advance enable.
REQ-016 Port res_sel, output, clog2(N*N): result word index to the array.
REQ-017 Port res_data, input, ACC_W: result word; the array drives it combinationally from res_sel.
REQ-018 Port data_out_z, output, 1: serial result bit, LSB first.
REQ-019 Port tx_ready, output, 1: high while data_out_z carries a valid bit.

Function
REQ-020 States: IDLE, LOAD, COMPUTE, TX_LOAD, TX_SHIFT, plus TX_PAR when the parity option is compiled in.
REQ-021 In IDLE or LOAD, each cycle with load_en=1 SHALL shift one X bit and one Y bit into the D_W-bit shift registers.
REQ-022 IDLE SHALL move to LOAD on the first captured bit.
REQ-023 A load_en=0 cycle SHALL pause the bit counter without losing captured bits.
REQ-024 The cycle after the D_W-th bit of a word, word_valid SHALL be 1 for exactly one cycle, with x_word and y_word holding that word.
REQ-025 x_word and y_word SHALL hold their values until the next word_valid.
REQ-026 When word_valid fires for word N*WORD-1, the next state SHALL be COMPUTE.
REQ-027 Any load_en bits arriving in or after that cycle, outside IDLE and LOAD, SHALL be ignored.
REQ-028 COMPUTE SHALL hold array_step=1 for exactly WORD+2*N-1 consecutive cycles, then go to TX_LOAD.
REQ-029 array_step SHALL be 0 in every other state.
REQ-030 TX_LOAD SHALL last 1 cycle and capture res_data for the current res_sel.
REQ-031 res_sel SHALL start at 0 on entry to TX_LOAD from COMPUTE.
REQ-032 TX_SHIFT SHALL output ACC_W bits, LSB first, one per cycle, with tx_ready=1.
REQ-033 After each word, res_sel SHALL increment and the state SHALL return to TX_LOAD.
REQ-034 After word N*N-1, the state SHALL return to IDLE and res_sel SHALL return to 0.
REQ-035 tx_ready SHALL be 0 in TX_LOAD, and data_out_z SHALL be 0 whenever tx_ready=0.
REQ-036 init=1 in IDLE SHALL pulse array_clear for 1 cycle and leave the state in IDLE.
REQ-037 init=1 in any other state SHALL abort to IDLE, pulse array_clear, and clear the bit, word and result counters.
REQ-038 On abort, no word_valid SHALL fire and tx_ready SHALL drop the next cycle.
REQ-039 init and load_en together SHALL give init priority; that bit SHALL be discarded.
REQ-040 Counters SHALL wrap only through explicit reset-to-0; no modular wrap SHALL occur mid-stream.

Reset
REQ-041 With rst=1 at a clock edge: state SHALL be IDLE.
REQ-042 With rst=1 at a clock edge: all counters, shift registers, x_word, y_word, res_sel, word_valid, array_clear, array_step, data_out_z and tx_ready SHALL be 0.
REQ-043 rst SHALL override init and load_en, including mid-operation; array_clear SHALL not pulse on reset.

Configuration
REQ-044 Macro TINYTPU_CTRL_PARITY_EN defined: after each result word, TX_PAR SHALL output one even-parity bit (XOR of the ACC_W bits) with tx_ready=1 before the next TX_LOAD or IDLE.
REQ-045 Macro TINYTPU_CTRL_PARITY_EN undefined: TX_PAR and the parity logic SHALL not exist, and TX_SHIFT SHALL go directly to TX_LOAD or IDLE.

Verification
REQ-046 Reset: assert rst during TX_SHIFT -> next cycle tx_ready=0, data_out_z=0, res_sel=0, state IDLE.
REQ-047 Load: stream X={1,2,3,4} and Y={5,6,7,8} with load_en continuous -> word_valid at cycles 8/16/24/32 after the first bit with matching x_word/y_word, then array_step high for 5 cycles.
REQ-048 Gap: deassert load_en for 3 cycles mid-word 1 -> word 1 value unchanged and its word_valid delayed by 3 cycles.
REQ-049 Transmit: stub res_data=0x1234 for all res_sel -> per word, data_out_z sequence 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 with tx_ready=1; 4 words; parity bit 1 when TINYTPU_CTRL_PARITY_EN is defined.
REQ-050 Abort: init=1 during COMPUTE cycle 2 -> array_clear pulses once, array_step=0 next cycle, state IDLE, no tx_ready.
REQ-051 Priority: init and load_en both high in IDLE -> array_clear pulse, no bit captured, first subsequent word matches the streamed value.

Source files
------------

// File: rtl/tinytpu_seq_ctrl.sv
// Sequencer for a small systolic array: deserialises X/Y operands, steps the array, then serialises results.
// Optional even-parity bit after each result word when TINYTPU_CTRL_PARITY_EN is defined.
module tinytpu_seq_ctrl #(
    parameter int D_W   = 8,
    parameter int N     = 2,
    parameter int WORD  = 2,
    parameter int ACC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_in_x,
    input  logic                     data_in_y,
    input  logic                     load_en,
    input  logic                     init,
    output logic [D_W-1:0]           x_word,
    output logic [D_W-1:0]           y_word,
    output logic                     word_valid,
    output logic                     array_clear,
    output logic                     array_step,
    output logic [$clog2(N*N)-1:0]   res_sel,
    input  logic [ACC_W-1:0]         res_data,
    output logic                     data_out_z,
    output logic                     tx_ready
);

    localparam int NWORDS = N * WORD;
    localparam int STEPS  = WORD + 2 * N - 1;
    localparam int NRES   = N * N;
    localparam int BC_W   = $clog2(D_W + 1);
    localparam int WC_W   = $clog2(NWORDS + 1);
    localparam int SC_W   = $clog2(STEPS + 1);
    localparam int TC_W   = $clog2(ACC_W + 1);
    localparam int RS_W   = $clog2(NRES);

    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(D_W - 1);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(NWORDS - 1);
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEPS - 1);
    localparam logic [TC_W-1:0] TX_LAST   = TC_W'(ACC_W - 1);
    localparam logic [RS_W-1:0] RES_LAST  = RS_W'(NRES - 1);

`ifdef TINYTPU_CTRL_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, TX_LOAD, TX_SHIFT, TX_PAR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, TX_LOAD, TX_SHIFT} state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [D_W-1:0]    x_sr;
    logic [D_W-1:0]    y_sr;
    logic [BC_W-1:0]   bit_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic [SC_W-1:0]   step_cnt;
    logic [TC_W-1:0]   tx_cnt;
    logic [ACC_W-1:0]  tx_sr;
`ifdef TINYTPU_CTRL_PARITY_EN
    logic              par;
`endif

    logic cap;
    logic word_done;
    logic last_word;
    logic step_last;
    logic tx_last;
    logic res_last;

    // Bits are only accepted while gathering operands; init always wins over load_en.
    assign cap       = load_en && !init && (state == IDLE || state == LOAD);
    assign word_done = cap && (bit_cnt == BIT_LAST);
    assign last_word = (word_cnt == WORD_LAST);
    assign step_last = (step_cnt == STEP_LAST);
    assign tx_last   = (tx_cnt == TX_LAST);
    assign res_last  = (res_sel == RES_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x_sr        <= '0;
            y_sr        <= '0;
            x_word      <= '0;
            y_word      <= '0;
            word_valid  <= 1'b0;
            array_clear <= 1'b0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            step_cnt    <= '0;
            tx_cnt      <= '0;
            tx_sr       <= '0;
            res_sel     <= '0;
`ifdef TINYTPU_CTRL_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            word_valid  <= 1'b0;
            array_clear <= init;
            if (init) begin
                bit_cnt  <= '0;
                word_cnt <= '0;
                step_cnt <= '0;
                tx_cnt   <= '0;
                res_sel  <= '0;
            end else begin
                if (cap) begin
                    // LSB arrives first, so shift in at the top and right-justify over D_W bits.
                    x_sr <= {data_in_x, x_sr[D_W-1:1]};
                    y_sr <= {data_in_y, y_sr[D_W-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt    <= '0;
                        x_word     <= {data_in_x, x_sr[D_W-1:1]};
                        y_word     <= {data_in_y, y_sr[D_W-1:1]};
                        word_valid <= 1'b1;
                        word_cnt   <= last_word ? '0 : word_cnt + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                case (state)
                    COMPUTE: begin
                        if (step_last) begin
                            step_cnt <= '0;
                            res_sel  <= '0;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                    TX_LOAD: begin
                        tx_sr  <= res_data;
                        tx_cnt <= '0;
`ifdef TINYTPU_CTRL_PARITY_EN
                        par    <= ^res_data;
`endif
                    end
                    TX_SHIFT: begin
                        tx_sr <= tx_sr >> 1;
                        if (tx_last) begin
                            tx_cnt <= '0;
`ifndef TINYTPU_CTRL_PARITY_EN
                            res_sel <= res_last ? '0 : res_sel + 1'b1;
`endif
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
`ifdef TINYTPU_CTRL_PARITY_EN
                    TX_PAR: begin
                        res_sel <= res_last ? '0 : res_sel + 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        array_step = 1'b0;
        tx_ready   = 1'b0;
        data_out_z = 1'b0;
        if (init) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cap) state_nxt = (word_done && last_word) ? COMPUTE : LOAD;
                end
                LOAD: begin
                    if (word_done && last_word) state_nxt = COMPUTE;
                end
                COMPUTE: begin
                    if (step_last) state_nxt = TX_LOAD;
                end
                TX_LOAD: state_nxt = TX_SHIFT;
                TX_SHIFT: begin
                    if (tx_last) begin
`ifdef TINYTPU_CTRL_PARITY_EN
                        state_nxt = TX_PAR;
`else
                        state_nxt = res_last ? IDLE : TX_LOAD;
`endif
                    end
                end
`ifdef TINYTPU_CTRL_PARITY_EN
                TX_PAR: state_nxt = res_last ? IDLE : TX_LOAD;
`endif
                default: state_nxt = IDLE;
            endcase
        end
        case (state)
            COMPUTE: array_step = 1'b1;
            TX_SHIFT: begin
                tx_ready   = 1'b1;
                data_out_z = tx_sr[0];
            end
`ifdef TINYTPU_CTRL_PARITY_EN
            TX_PAR: begin
                tx_ready   = 1'b1;
                data_out_z = par;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tinytpu_seq_ctrl.sv
// Bench for tinytpu_seq_ctrl: table of load/transmit transactions checked through a scoreboard,
// plus hand-written abort, init/load priority and mid-transmit reset sequences.
module tb_tinytpu_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        data_in_x;
    logic        data_in_y;
    logic        load_en;
    logic        init;
    logic [7:0]  x_word;
    logic [7:0]  y_word;
    logic        word_valid;
    logic        array_clear;
    logic        array_step;
    logic [1:0]  res_sel;
    logic [15:0] res_data;
    logic        data_out_z;
    logic        tx_ready;

    tinytpu_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .data_in_x  (data_in_x),
        .data_in_y  (data_in_y),
        .load_en    (load_en),
        .init       (init),
        .x_word     (x_word),
        .y_word     (y_word),
        .word_valid (word_valid),
        .array_clear(array_clear),
        .array_step (array_step),
        .res_sel    (res_sel),
        .res_data   (res_data),
        .data_out_z (data_out_z),
        .tx_ready   (tx_ready)
    );

`ifdef TINYTPU_CTRL_PARITY_EN
    localparam int BITS_PER_RES = 17;
`else
    localparam int BITS_PER_RES = 16;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array stub: result word depends on res_sel so the index sequence is visible in the stream.
    logic [15:0] cur_res;
    logic [15:0] cur_inc;
    assign res_data = cur_res + 16'(res_sel) * cur_inc;

    typedef struct {
        logic [3:0][7:0] xs;
        logic [3:0][7:0] ys;
        int              gap_word;
        int              gap_len;
        logic [15:0]     res;
        logic [15:0]     inc;
        logic [3:0][7:0] exp_wv;
    } vec_t;

    typedef struct {
        logic [15:0] xy;
        int          c;
    } wobs_t;

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wobs_t obs_w[$];
    int    step_q[$];
    int    clr_q[$];
    logic  bit_q[$];
    int    bad_z = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid) obs_w.push_back('{xy: {x_word, y_word}, c: cyc});
            if (array_step) step_q.push_back(cyc);
            if (array_clear) clr_q.push_back(cyc);
            if (tx_ready) bit_q.push_back(data_out_z);
            else if (data_out_z !== 1'b0) bad_z++;
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_w[$];
    int          exp_c[$];
    logic        exp_b[$];
    int          rd_w = 0;
    int          rd_b = 0;
    int          t0, s0, c0;
    vec_t        tbl[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input vec_t v, input bit pre_init, input bit junk, input bit push_tx);
        int p;
        repeat (2) tick();
        cur_res = v.res;
        cur_inc = v.inc;
        c0 = clr_q.size();
        if (pre_init) begin
            p = cyc;
            init = 1'b1; load_en = 1'b1; data_in_x = 1'b1; data_in_y = 1'b1;
            tick();
            init = 1'b0; load_en = 1'b0;
            tick();
            chk("prio_clear_count", clr_q.size() - c0, 1);
            if (clr_q.size() > c0) chk("prio_clear_cycle", clr_q[c0], p + 1);
        end
        s0 = step_q.size();
        t0 = cyc;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 8; b++) begin
                if (w == v.gap_word && b == 4) begin
                    load_en = 1'b0; data_in_x = 1'b1; data_in_y = 1'b1;
                    repeat (v.gap_len) tick();
                end
                load_en = 1'b1;
                data_in_x = v.xs[w][b];
                data_in_y = v.ys[w][b];
                if (b == 7) begin
                    exp_w.push_back({v.xs[w], v.ys[w]});
                    exp_c.push_back(t0 + int'(v.exp_wv[w]));
                end
                tick();
            end
        end
        if (junk) begin
            repeat (2) begin
                data_in_x = 1'b1; data_in_y = 1'b0;
                tick();
            end
        end
        load_en = 1'b0;
        if (push_tx) begin
            for (int r = 0; r < 4; r++) begin
                logic [15:0] wv;
                wv = v.res + 16'(r) * v.inc;
                for (int i = 0; i < 16; i++) exp_b.push_back(wv[i]);
`ifdef TINYTPU_CTRL_PARITY_EN
                exp_b.push_back(^wv);
`endif
            end
        end
    endtask

    task automatic cmp_words();
        for (int j = rd_w; j < obs_w.size(); j++) begin
            if (exp_w.size() == 0) begin
                chk("extra_word_valid", 1, 0);
            end else begin
                chk($sformatf("word%0d_xy", j), obs_w[j].xy, exp_w.pop_front());
                chk($sformatf("word%0d_cycle", j), obs_w[j].c - t0, exp_c.pop_front() - t0);
            end
        end
        rd_w = obs_w.size();
        chk("missing_words", exp_w.size(), 0);
        exp_w.delete();
        exp_c.delete();
    endtask

    task automatic finish_vec(input vec_t v);
        int k;
        int need;
        need = 4 * BITS_PER_RES;
        k = 0;
        while (bit_q.size() - rd_b < need && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) chk("tx_timeout", 1, 0);
        repeat (4) tick();
        cmp_words();
        chk("step_count", step_q.size() - s0, 5);
        if (step_q.size() > s0) begin
            chk("step_start", step_q[s0] - t0, int'(v.exp_wv[3]));
            chk("step_contig", step_q[step_q.size() - 1] - step_q[s0], 4);
        end
        for (int j = rd_b; j < bit_q.size(); j++) begin
            if (exp_b.size() == 0) chk("extra_tx_bit", 1, 0);
            else chk($sformatf("tx_bit%0d", j - rd_b), bit_q[j], exp_b.pop_front());
        end
        rd_b = bit_q.size();
        chk("missing_tx_bits", exp_b.size(), 0);
        exp_b.delete();
        chk("idle_res_sel", res_sel, 0);
        chk("idle_tx_ready", tx_ready, 0);
    endtask

    initial begin
        int k;
        rst = 1'b1; init = 1'b0; load_en = 1'b0; data_in_x = 1'b0; data_in_y = 1'b0;
        cur_res = 16'h0; cur_inc = 16'h0;
        repeat (3) tick();
        chk("rst_words", {x_word, y_word}, 0);
        chk("rst_strobes", {word_valid, array_clear, array_step}, 0);
        chk("rst_res_sel", res_sel, 0);
        chk("rst_tx", {tx_ready, data_out_z}, 0);
        rst = 1'b0;

        tbl[0].xs = {8'd4, 8'd3, 8'd2, 8'd1};
        tbl[0].ys = {8'd8, 8'd7, 8'd6, 8'd5};
        tbl[0].gap_word = -1; tbl[0].gap_len = 0;
        tbl[0].res = 16'h1234; tbl[0].inc = 16'h0000;
        tbl[0].exp_wv = {8'd32, 8'd24, 8'd16, 8'd8};

        tbl[1].xs = {8'h81, 8'h00, 8'hFF, 8'hA5};
        tbl[1].ys = {8'h7E, 8'h80, 8'h01, 8'h3C};
        tbl[1].gap_word = 1; tbl[1].gap_len = 3;
        tbl[1].res = 16'hBEEF; tbl[1].inc = 16'h0101;
        tbl[1].exp_wv = {8'd35, 8'd27, 8'd19, 8'd8};

        tbl[2].xs = {8'h55, 8'hC3, 8'h0F, 8'hFF};
        tbl[2].ys = {8'hAA, 8'h3C, 8'hF0, 8'h00};
        tbl[2].gap_word = 0; tbl[2].gap_len = 1;
        tbl[2].res = 16'hFFFF; tbl[2].inc = 16'h0000;
        tbl[2].exp_wv = {8'd33, 8'd25, 8'd17, 8'd9};

        for (int i = 0; i < 3; i++) begin
            load_vec(tbl[i], 1'b0, 1'b1, 1'b1);
            finish_vec(tbl[i]);
        end

        // init together with load_en in IDLE: clear pulse, that bit dropped
        load_vec(tbl[1], 1'b1, 1'b0, 1'b1);
        finish_vec(tbl[1]);

        // abort in the second COMPUTE cycle
        load_vec(tbl[0], 1'b0, 1'b0, 1'b0);
        c0 = clr_q.size();
        k = 0;
        while (!array_step && k < 10) begin tick(); k++; end
        chk("abort_compute_reached", array_step, 1);
        tick();
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("abort_step_drop", array_step, 0);
        chk("abort_clear_on", array_clear, 1);
        tick();
        chk("abort_clear_off", array_clear, 0);
        repeat (40) tick();
        chk("abort_step_count", step_q.size() - s0, 2);
        chk("abort_clear_count", clr_q.size() - c0, 1);
        chk("abort_no_tx", bit_q.size() - rd_b, 0);
        chk("abort_res_sel", res_sel, 0);
        cmp_words();

        // synchronous reset in the middle of transmitting result word 1
        load_vec(tbl[2], 1'b0, 1'b0, 1'b0);
        c0 = clr_q.size();
        k = 0;
        while (!(tx_ready && res_sel == 2'd1) && k < 300) begin tick(); k++; end
        chk("rst_tx_reached", {tx_ready, res_sel}, 3'b101);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx_ready", tx_ready, 0);
        chk("midrst_z", data_out_z, 0);
        chk("midrst_res_sel", res_sel, 0);
        chk("midrst_step_clear", {array_step, array_clear}, 0);
        tick();
        chk("midrst_no_clear", clr_q.size() - c0, 0);
        cmp_words();
        rd_b = bit_q.size();

        load_vec(tbl[0], 1'b0, 1'b1, 1'b1);
        finish_vec(tbl[0]);

        chk("z_low_when_not_ready", bad_z, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
